video_ts_sched: RTL and testbench

Task scheduler in front of the TS-line renderer. It queues tile/sprite render tasks posted by the TS list scanner in a small FIFO. It issues them to the renderer as back-to-back `tsr_go` strobes whenever the renderer reports `mem_rdy`. It enforces a per-line DRAM-cycle budget so TS fetches never overrun the line's allotted bandwidth.

---
 rtl/video_ts_sched.sv | 135 +++++++++++++
 tb/tb_video_ts_sched.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_ts_sched.sv
// TS render task scheduler: queues scanner tasks and issues them to the
// TS-line renderer under a per-line DRAM-cycle budget.
module video_ts_sched #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_start,
  input  logic [8:0] budget,
  input  logic       task_we,
  input  logic [8:0] task_x,
  input  logic [2:0] task_xs,
  input  logic       task_flip,
  input  logic [3:0] task_pal,
  input  logic [5:0] task_addr,
  input  logic [8:0] task_line,
  input  logic [7:0] task_page,
  output logic       task_full,
  output logic       ren_reset,
  output logic       ren_go,
  output logic [8:0] ren_x_coord,
  output logic [2:0] ren_x_size,
  output logic       ren_flip,
  output logic [3:0] ren_pal,
  output logic [5:0] ren_addr,
  output logic [8:0] ren_line,
  output logic [7:0] ren_page,
  input  logic       ren_mem_rdy,
  output logic       idle,
  output logic       overflow,
  output logic       starved
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [8:0] x;
    logic [2:0] xs;
    logic       flip;
    logic [3:0] pal;
    logic [5:0] addr;
    logic [8:0] line;
    logic [7:0] page;
  } task_t;

  task_t          mem [DEPTH];
  task_t          head;
  task_t          wr_data;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [AW:0]    count;
  logic [8:0]     left;
  logic [8:0]     cost;
  logic           empty;
  logic           full;
  logic           fits;
  logic           pop;
  logic           push;

  assign head = mem[rd_ptr];

  assign wr_data = '{
    x:    task_x,
    xs:   task_xs,
    flip: task_flip,
    pal:  task_pal,
    addr: task_addr,
    line: task_line,
    page: task_page
  };

  // Two DRAM words are fetched per render cycle of the sprite.
  assign cost  = {5'd0, head.xs, 1'b0} + 9'd2;
  assign fits  = left >= cost;
  assign empty = count == '0;
  assign full  = count == FULL_CNT;

  assign ren_go = !line_start && !empty && ren_mem_rdy && fits;
  assign pop    = ren_go;
  assign push   = task_we && !line_start && (!full || pop);

  assign task_full = full;
  assign ren_reset = line_start;
  assign idle      = empty && ren_mem_rdy;

  assign ren_x_coord = head.x;
  assign ren_x_size  = head.xs;
  assign ren_flip    = head.flip;
  assign ren_pal     = head.pal;
  assign ren_addr    = head.addr;
  assign ren_line    = head.line;
  assign ren_page    = head.page;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      left     <= '0;
      overflow <= 1'b0;
      starved  <= 1'b0;
    end else if (line_start) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      left     <= budget;
      overflow <= 1'b0;
      starved  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        left   <= left - cost;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (task_we && full && !pop)
        overflow <= 1'b1;
      // Head stalls for the rest of the line once it no longer fits.
      if (!empty && ren_mem_rdy && !fits)
        starved <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_video_ts_sched.sv
// Self-checking bench for video_ts_sched: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_video_ts_sched;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       line_start;
  logic [8:0] budget;
  logic       task_we;
  logic [8:0] task_x;
  logic [2:0] task_xs;
  logic       task_flip;
  logic [3:0] task_pal;
  logic [5:0] task_addr;
  logic [8:0] task_line;
  logic [7:0] task_page;
  logic       task_full;
  logic       ren_reset;
  logic       ren_go;
  logic [8:0] ren_x_coord;
  logic [2:0] ren_x_size;
  logic       ren_flip;
  logic [3:0] ren_pal;
  logic [5:0] ren_addr;
  logic [8:0] ren_line;
  logic [7:0] ren_page;
  logic       ren_mem_rdy;
  logic       idle;
  logic       overflow;
  logic       starved;

  video_ts_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .line_start(line_start),
    .budget(budget),
    .task_we(task_we),
    .task_x(task_x),
    .task_xs(task_xs),
    .task_flip(task_flip),
    .task_pal(task_pal),
    .task_addr(task_addr),
    .task_line(task_line),
    .task_page(task_page),
    .task_full(task_full),
    .ren_reset(ren_reset),
    .ren_go(ren_go),
    .ren_x_coord(ren_x_coord),
    .ren_x_size(ren_x_size),
    .ren_flip(ren_flip),
    .ren_pal(ren_pal),
    .ren_addr(ren_addr),
    .ren_line(ren_line),
    .ren_page(ren_page),
    .ren_mem_rdy(ren_mem_rdy),
    .idle(idle),
    .overflow(overflow),
    .starved(starved)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] x;
    logic [2:0] xs;
    logic       flip;
    logic [3:0] pal;
    logic [5:0] addr;
    logic [8:0] line;
    logic [7:0] page;
  } tsk_t;

  tsk_t q[$];
  int   m_left;
  bit   m_ovf;
  bit   m_starv;
  int   checks;
  int   errors;
  int   go_cnt;
  bit   auto_rdy;
  int   busy;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cost_of(input tsk_t t);
    return 2 * (int'(t.xs) + 1);
  endfunction

  function automatic bit exp_go();
    if (reset || line_start || q.size() == 0 || !ren_mem_rdy)
      return 1'b0;
    return m_left >= cost_of(q[0]);
  endfunction

  task automatic model_clear(input int l);
    q.delete();
    m_left  = l;
    m_ovf   = 1'b0;
    m_starv = 1'b0;
  endtask

  task automatic cycle();
    tsk_t cur;
    tsk_t hd;
    bit   g;
    int   n;
    @(negedge clk);
    g = exp_go();
    check("go", ren_go, g);
    check("full", task_full, q.size() == DEPTH);
    check("idle", idle, q.size() == 0 && ren_mem_rdy);
    check("ovf", overflow, m_ovf);
    check("starv", starved, m_starv);
    check("rst_fwd", ren_reset, line_start);
    if (g) begin
      hd = q[0];
      check("fields", {ren_x_coord, ren_x_size, ren_flip, ren_pal,
                       ren_addr, ren_line, ren_page}, hd);
    end
    cur = {task_x, task_xs, task_flip, task_pal,
           task_addr, task_line, task_page};
    @(posedge clk);
    if (reset) begin
      model_clear(0);
    end else if (line_start) begin
      model_clear(int'(budget));
    end else begin
      n = q.size();
      if (g) begin
        m_left -= cost_of(q[0]);
        void'(q.pop_front());
        go_cnt++;
      end
      if (task_we) begin
        if (n < DEPTH || g) q.push_back(cur);
        else m_ovf = 1'b1;
      end
      if (n > 0 && ren_mem_rdy && !g) m_starv = 1'b1;
    end
    #1;
    if (auto_rdy) begin
      if (g) busy = $urandom_range(2, 4);
      if (busy > 0) begin
        ren_mem_rdy = 1'b0;
        busy--;
      end else begin
        ren_mem_rdy = 1'b1;
      end
    end
  endtask

  task automatic set_task(input logic [2:0] xs);
    task_x    = 9'($urandom);
    task_xs   = xs;
    task_flip = 1'($urandom);
    task_pal  = 4'($urandom);
    task_addr = 6'($urandom);
    task_line = 9'($urandom);
    task_page = 8'($urandom);
  endtask

  task automatic push(input logic [2:0] xs);
    set_task(xs);
    task_we = 1'b1;
    cycle();
    task_we = 1'b0;
  endtask

  task automatic new_line(input logic [8:0] b);
    budget     = b;
    line_start = 1'b1;
    cycle();
    line_start = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int k;
    k = 0;
    while (q.size() != 0 && k < max_cyc) begin
      cycle();
      k++;
    end
    check("drain_timeout", k < max_cyc, 1'b1);
  endtask

  int g0;

  initial begin
    checks      = 0;
    errors      = 0;
    go_cnt      = 0;
    busy        = 0;
    auto_rdy    = 1'b0;
    reset       = 1'b1;
    line_start  = 1'b0;
    budget      = '0;
    task_we     = 1'b0;
    ren_mem_rdy = 1'b1;
    set_task(3'd0);
    model_clear(0);

    // reset state
    cycle();
    cycle();
    check("rst_left", dut.left, 0);
    reset = 1'b0;
    cycle();

    // basic issue of three tasks
    auto_rdy = 1'b1;
    new_line(9'd100);
    push(3'd0);
    push(3'd3);
    push(3'd7);
    drain(60);
    repeat (4) cycle();
    check("t1_left", dut.left, 74);
    check("t1_mleft", m_left, 74);
    check("t1_idle", idle, 1'b1);

    // budget exhaustion
    new_line(9'd10);
    g0 = go_cnt;
    push(3'd3);
    push(3'd0);
    push(3'd0);
    repeat (20) cycle();
    check("t2_gos", go_cnt - g0, 2);
    check("t2_starv", starved, 1'b1);
    check("t2_count", dut.count, 1);

    // overflow while renderer is stalled
    auto_rdy = 1'b0;
    busy = 0;
    ren_mem_rdy = 1'b0;
    new_line(9'd200);
    g0 = go_cnt;
    repeat (4) push(3'($urandom));
    check("t3_full", task_full, 1'b1);
    push(3'($urandom));
    check("t3_ovf", overflow, 1'b1);
    auto_rdy = 1'b1;
    ren_mem_rdy = 1'b1;
    repeat (40) cycle();
    check("t3_gos", go_cnt - g0, 4);

    // push and pop together while full
    auto_rdy = 1'b0;
    busy = 0;
    ren_mem_rdy = 1'b0;
    new_line(9'd200);
    repeat (4) push(3'd1);
    g0 = go_cnt;
    ren_mem_rdy = 1'b1;
    push(3'd2);
    ren_mem_rdy = 1'b0;
    check("t4_go", go_cnt - g0, 1);
    check("t4_ovf", overflow, 1'b0);
    check("t4_count", dut.count, 4);
    cycle();

    // line_start beats a coincident push and go
    new_line(9'd200);
    push(3'd1);
    push(3'd2);
    g0 = go_cnt;
    ren_mem_rdy = 1'b1;
    set_task(3'd4);
    task_we = 1'b1;
    new_line(9'd55);
    task_we = 1'b0;
    ren_mem_rdy = 1'b0;
    check("t5_go", go_cnt - g0, 0);
    check("t5_count", dut.count, 0);
    check("t5_left", dut.left, 55);
    check("t5_flags", {overflow, starved}, 2'b00);
    cycle();

    // async reset between edges
    new_line(9'd200);
    push(3'd1);
    push(3'd1);
    #2;
    reset = 1'b1;
    ren_mem_rdy = 1'b1;
    model_clear(0);
    #1;
    check("t6_go", ren_go, 1'b0);
    check("t6_full", task_full, 1'b0);
    check("t6_idle", idle, 1'b1);
    check("t6_flags", {overflow, starved}, 2'b00);
    cycle();
    reset = 1'b0;
    g0 = go_cnt;
    repeat (5) cycle();
    check("t6_nogo", go_cnt - g0, 0);
    auto_rdy = 1'b1;
    new_line(9'd50);
    push(3'd2);
    drain(20);
    check("t6_go_after", go_cnt - g0, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      set_task(3'($urandom));
      task_we    = ($urandom_range(0, 99) < 45);
      line_start = ($urandom_range(0, 99) < 3);
      budget     = 9'($urandom_range(0, 160));
      cycle();
      task_we    = 1'b0;
      line_start = 1'b0;
    end
    check("rnd_left", dut.left, m_left);
    check("rnd_count", dut.count, q.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
